// File: rtl/sd_adc_pkg.sv
// Shared sigma-delta path constants: default word width, interpolation depth and derived accumulator width.
// Imported by both the box averager and the box interpolator so their scaling always matches.
package sd_adc_pkg;

    localparam int ADC_WIDTH_DEF      = 8;
    localparam int LPF_DEPTH_BITS_DEF = 4;
    localparam int ACC_WIDTH_DEF      = ADC_WIDTH_DEF + LPF_DEPTH_BITS_DEF;

    function automatic int acc_width(input int adc_w, input int lpf_bits);
        return adc_w + lpf_bits;
    endfunction

endpackage

// File: rtl/sample_rise_det.sv
// Two-flop rising-edge detector on the output-rate strobe; step is combinational from the flops.
// One step per rising edge, however long the strobe is held high; no backpressure.
module sample_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic sample,
    output logic step
);

    logic r_sample_d1;
    logic r_sample_d2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_d1 <= 1'b0;
            r_sample_d2 <= 1'b0;
        end else begin
            r_sample_d1 <= sample;
            r_sample_d2 <= r_sample_d1;
        end
    end

    assign step = r_sample_d1 & ~r_sample_d2;

endmodule

// File: rtl/box_interp.sv
// Linear interpolating upsampler: output registers one clock after the strobe rise is sampled.
// One-word pending buffer; data_in_ready drops while it is full, except on the segment-start cycle.
module box_interp
    import sd_adc_pkg::*;
#(
    parameter int ADC_WIDTH      = ADC_WIDTH_DEF,
    parameter int LPF_DEPTH_BITS = LPF_DEPTH_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample,
    input  logic [ADC_WIDTH-1:0] data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [ADC_WIDTH-1:0] interp_data_out,
    output logic                 data_out_valid,
    output logic                 underrun
);

    localparam int ACC_WIDTH = acc_width(ADC_WIDTH, LPF_DEPTH_BITS);

    logic                        w_step;
    logic                        w_seg_start;
    logic                        w_accept;
    logic signed [ADC_WIDTH:0]   w_new_delta;
    logic [ACC_WIDTH-1:0]        w_acc_seed;

    logic [ADC_WIDTH-1:0]        r_pend;
    logic                        r_pend_full;
    logic [ADC_WIDTH-1:0]        r_target;
    logic signed [ADC_WIDTH:0]   r_delta;
    logic [ACC_WIDTH-1:0]        r_acc;
    logic [LPF_DEPTH_BITS-1:0]   r_count;

    sample_rise_det u_rise (
        .clk    (clk),
        .rst    (rst),
        .sample (sample),
        .step   (w_step)
    );

    assign w_seg_start   = w_step & (r_count == '0);
    assign data_in_ready = ~r_pend_full | w_seg_start;
    assign w_accept      = data_in_valid & data_in_ready;

    assign w_new_delta = $signed({1'b0, r_pend}) - $signed({1'b0, r_target});
    assign w_acc_seed  = {r_target, {LPF_DEPTH_BITS{1'b0}}};

    // Sign-extending casts keep the modular add exact; acc never leaves the unsigned output range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interp_data_out <= '0;
            data_out_valid  <= 1'b0;
            underrun        <= 1'b0;
            r_pend          <= '0;
            r_pend_full     <= 1'b0;
            r_target        <= '0;
            r_delta         <= '0;
            r_acc           <= '0;
            r_count         <= '0;
        end else begin
            data_out_valid <= w_step;
            underrun       <= w_seg_start & ~r_pend_full;

            if (w_step) begin
                r_count <= r_count + LPF_DEPTH_BITS'(1);
            end

            if (w_seg_start) begin
                interp_data_out <= r_target;
                if (r_pend_full) begin
                    r_delta  <= w_new_delta;
                    r_acc    <= w_acc_seed + ACC_WIDTH'(w_new_delta);
                    r_target <= r_pend;
                end else begin
                    r_delta <= '0;
                    r_acc   <= w_acc_seed;
                end
            end else if (w_step) begin
                interp_data_out <= r_acc[ACC_WIDTH-1:LPF_DEPTH_BITS];
                r_acc           <= r_acc + ACC_WIDTH'(r_delta);
            end

            // A word accepted on the consuming cycle replaces the one handed to the segment.
            if (w_accept) begin
                r_pend      <= data_in;
                r_pend_full <= 1'b1;
            end else if (w_seg_start) begin
                r_pend_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_box_interp.sv
// Scoreboard bench for box_interp at ADC_WIDTH=8, LPF_DEPTH_BITS=2.
module tb_box_interp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample = 1'b0;
    logic [7:0] data_in = '0;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic [7:0] interp_data_out;
    logic       data_out_valid;
    logic       underrun;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] val;
        logic       unf;
    } exp_t;

    exp_t sb_q[$];

    box_interp #(.ADC_WIDTH(8), .LPF_DEPTH_BITS(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .sample          (sample),
        .data_in         (data_in),
        .data_in_valid   (data_in_valid),
        .data_in_ready   (data_in_ready),
        .interp_data_out (interp_data_out),
        .data_out_valid  (data_out_valid),
        .underrun        (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Output monitor: every data_out_valid pops one expected word.
    always @(negedge clk) begin
        if (!rst && (data_out_valid || underrun)) begin
            if (underrun && !data_out_valid) begin
                chk("unf_no_vld", {31'd0, data_out_valid}, 32'd1);
            end else if (sb_q.size() == 0) begin
                chk("unexpected_vld", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("out", {24'd0, interp_data_out}, {24'd0, e.val});
                chk("unf", {31'd0, underrun}, {31'd0, e.unf});
            end
        end
    end

    task automatic strobe(input logic [7:0] v, input logic u, input int hold);
        exp_t e;
        e.val = v;
        e.unf = u;
        sb_q.push_back(e);
        @(negedge clk);
        sample = 1'b1;
        repeat (hold) @(negedge clk);
        sample = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] w);
        bit done;
        done = 1'b0;
        @(negedge clk);
        data_in       = w;
        data_in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (data_in_ready) begin
                @(posedge clk);
                #1 data_in_valid = 1'b0;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            data_in_valid = 1'b0;
            chk("send_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out", {24'd0, interp_data_out}, 32'd0);
        chk("rst_vld", {31'd0, data_out_valid}, 32'd0);
        chk("rst_unf", {31'd0, underrun}, 32'd0);
        chk("rst_rdy", {31'd0, data_in_ready}, 32'd1);
        rst = 1'b0;

        // Ramp up 0 -> 100, then ramp down to 20 (strobe held high once).
        send(8'd100);
        strobe(8'd0, 1'b0, 1);
        strobe(8'd25, 1'b0, 3);
        strobe(8'd50, 1'b0, 1);
        strobe(8'd75, 1'b0, 1);
        send(8'd20);
        strobe(8'd100, 1'b0, 1);
        strobe(8'd80, 1'b0, 1);
        strobe(8'd60, 1'b0, 1);
        strobe(8'd40, 1'b0, 1);

        // Back to 0, then the truncating 0 -> 3 segment.
        send(8'd0);
        strobe(8'd20, 1'b0, 1);
        strobe(8'd15, 1'b0, 1);
        strobe(8'd10, 1'b0, 1);
        strobe(8'd5, 1'b0, 1);
        send(8'd3);
        strobe(8'd0, 1'b0, 1);
        strobe(8'd0, 1'b0, 1);
        strobe(8'd1, 1'b0, 1);
        strobe(8'd2, 1'b0, 1);

        // 3 -> 100, then a starved segment holding at 100.
        send(8'd100);
        strobe(8'd3, 1'b0, 1);
        strobe(8'd27, 1'b0, 1);
        strobe(8'd51, 1'b0, 1);
        strobe(8'd75, 1'b0, 1);
        strobe(8'd100, 1'b1, 1);
        strobe(8'd100, 1'b0, 1);
        strobe(8'd100, 1'b0, 1);
        strobe(8'd100, 1'b0, 1);

        // Back-pressure: 40 pending, 60 offered until the segment start swaps them.
        send(8'd40);
        @(negedge clk);
        data_in       = 8'd60;
        data_in_valid = 1'b1;
        chk("bp_rdy0_a", {31'd0, data_in_ready}, 32'd0);
        @(negedge clk);
        chk("bp_rdy0_b", {31'd0, data_in_ready}, 32'd0);
        begin
            exp_t e;
            e.val = 8'd100;
            e.unf = 1'b0;
            sb_q.push_back(e);
        end
        sample = 1'b1;
        @(negedge clk);
        chk("bp_rdy_swap", {31'd0, data_in_ready}, 32'd1);
        sample = 1'b0;
        @(posedge clk);
        #1 data_in_valid = 1'b0;
        @(negedge clk);
        chk("bp_still_full", {31'd0, data_in_ready}, 32'd0);
        @(negedge clk);
        strobe(8'd85, 1'b0, 1);
        strobe(8'd70, 1'b0, 1);
        strobe(8'd55, 1'b0, 1);
        strobe(8'd40, 1'b0, 1);
        strobe(8'd45, 1'b0, 1);

        // Fresh start, then 0 -> 200 cut by an asynchronous reset at count 2.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(8'd200);
        strobe(8'd0, 1'b0, 1);
        strobe(8'd50, 1'b0, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_out", {24'd0, interp_data_out}, 32'd0);
        chk("arst_vld", {31'd0, data_out_valid}, 32'd0);
        chk("arst_unf", {31'd0, underrun}, 32'd0);
        chk("arst_rdy", {31'd0, data_in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        strobe(8'd0, 1'b1, 1);
        strobe(8'd0, 1'b0, 1);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/box_interp.md
# box_interp

Linear interpolating upsampler for the sigma-delta signal path. It accepts decimated words over a valid/ready handshake and produces one output word per `sample` rising edge, ramping linearly from the previous word to the new one over 2^LPF_DEPTH_BITS sample periods. It is the reconstruction-side counterpart of the box averager. Its output feeds the DAC modulator, or a bench comparing against the averager input.

## Interface
- `ADC_WIDTH`, default 8: data word width, unsigned.
- `LPF_DEPTH_BITS`, default 4: interpolation ratio is 2^LPF_DEPTH_BITS output samples per input word.

- `clk`  in  1: sample-rate clock.
- `rst`  in  1: reset. One clock; reset is asynchronous and active-high.
- `sample`  in  1: output-rate strobe. Its rising edge requests one output word.
- `data_in`  in  ADC_WIDTH: decimated input word.
- `data_in_valid`  in  1: `data_in` is offered.
- `data_in_ready`  out  1: block accepts `data_in` on this cycle.
- `interp_data_out`  out  ADC_WIDTH: interpolated output word.
- `data_out_valid`  out  1: single-cycle pulse; `interp_data_out` updated.
- `underrun`  out  1: single-cycle pulse, aligned with `data_out_valid`; a segment started with no pending word.

## Operation
- **Edge detect.**
  - `sample_d1` and `sample_d2` are pipeline flops.
  - `step = sample_d1 & ~sample_d2`.
  - `seg_start = step & (count == 0)`.
- **Pending buffer.** One word deep: `pend`, plus flag `pend_full`.
  - `data_in_ready = ~pend_full | seg_start`.
  - Accept occurs when `data_in_valid & data_in_ready`; it writes `pend` and sets `pend_full`.
  - If `seg_start` consumes `pend` and a new word is accepted in the same cycle, `pend_full` stays 1 and holds the new word.
- **Segment registers.**
  - `target` (ADC_WIDTH): endpoint of the current segment.
  - `delta` (signed, ADC_WIDTH+1).
  - `acc` (ADC_WIDTH+LPF_DEPTH_BITS): value scaled by 2^LPF_DEPTH_BITS.
  - `count` (LPF_DEPTH_BITS): free-running phase, increments on every `step` and wraps naturally.
- **On `seg_start`:**
  - `interp_data_out <= target`.
  - If `pend_full`: `delta <= pend - target`, `acc <= (target << LPF_DEPTH_BITS) + (pend - target)`, `target <= pend`.
  - Otherwise: `delta <= 0`, `acc <= target << LPF_DEPTH_BITS`, and `underrun` pulses.
- **On a `step` with `count != 0`:** `interp_data_out <= acc >> LPF_DEPTH_BITS`, `acc <= acc + delta` (sign-extended add).
- **Arithmetic.**
  - `acc` stays within [0, (2^ADC_WIDTH - 1) << LPF_DEPTH_BITS] by construction, so no saturation is required.
  - The output truncates toward zero; no rounding.
- **Resulting sequence.** Word k is reached exactly at the start of segment k+1. Intermediate outputs are `target_old + floor(delta*i / 2^N)` for i = 0 .. 2^N−1.

## Timing
- **Latency.** Let E0 be the clock edge that first samples `sample` high. `interp_data_out`, `data_out_valid` and `underrun` register at E0+1, and the pulses are high for exactly one cycle.
- **Strobe spacing.** `sample` must be low for at least 1 clk between rising edges. A `sample` held high produces exactly one step.
- **Reset values.** While `rst` is asserted, every register is 0: `interp_data_out`=0, `data_out_valid`=0, `underrun`=0, `pend_full`=0, `count`=0, `target`=0, `acc`=0, `delta`=0. `data_in_ready`=1.
- **Reset mid-segment** discards both the pending word and the segment. After release the output starts from 0.
- **Before the first word** arrives, every segment start is an underrun and the output holds at 0.
- **Underrun.** The output holds at `target` for a full segment. The next accepted word is used at the following `seg_start`.
- **Back-pressure.** With `pend_full`=1 and no `seg_start`, `data_in_ready`=0. The input must hold `data_in` stable.

## Structure
- Shared package `sd_adc_pkg`:
  - default `ADC_WIDTH`/`LPF_DEPTH_BITS` constants;
  - derived `ACC_WIDTH = ADC_WIDTH + LPF_DEPTH_BITS`.
  - The averager and the interpolator both import these.
- One sub-module, `sample_rise_det`: the two-flop rising-edge detector on `sample`, outputting `step`. It is reusable by the averager.
- All remaining logic is a single module (target 150–250 lines).

## Test plan
All scenarios use LPF_DEPTH_BITS=2 and ADC_WIDTH=8.
- **Ramp up.** Reset, then load 100 before the first strobe, then 5 strobes. Output 0, 25, 50, 75, 100. No `underrun`.
- **Ramp down.** Continue from the ramp-up state: load 20, then 4 strobes. Output 100, 80, 60, 40; the next segment start outputs 20.
- **Truncation.** From target 0, load 3, then 5 strobes. Output 0, 0, 1, 2, 3.
- **Underrun hold.** From target 100, present no word for 4 strobes. Output 100 ×4; `underrun` pulses once, with the first `data_out_valid`.
- **Back-pressure and same-cycle swap.**
  - Fill `pend` with 40, then offer 60 continuously.
  - `data_in_ready` stays 0 until `seg_start`.
  - 60 is accepted in the same cycle that 40 is consumed, and `pend_full` remains 1.
- **Reset mid-segment.** Assert `rst` at `count`=2 during a 0→200 ramp. All outputs are 0 immediately (asynchronous). After release, the first strobe outputs 0 with an `underrun` pulse.
